// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned DEF_ADDR_W    = 4;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEPTH         = 2 ** DEF_ADDR_W;
  localparam int unsigned DEF_CPU_BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_rr_pick.sv
// Grant decision between CPU and debug ports, with the CPU streak limiter.
module dmem_rr_pick
  import dmem_pkg::*;
#(
  parameter int unsigned CPU_BURST = DEF_CPU_BURST
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   hold,
  input  logic   cpu_req,
  input  logic   dbg_req,
  output owner_e owner_c
);

  localparam int unsigned STREAK_W = $clog2(CPU_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CPU_BURST);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;

  // CPU has priority until it has won CPU_BURST times in a row against a waiting dbg
  always_comb begin
    owner_c = NONE;
    if (!hold) begin
      if (cpu_req && dbg_req) begin
        owner_c = (streak == STREAK_MAX) ? DBG : CPU;
      end else if (cpu_req) begin
        owner_c = CPU;
      end else if (dbg_req) begin
        owner_c = DBG;
      end
    end
  end

  always_comb begin
    streak_nxt = streak;
    if (!hold) begin
      if (!dbg_req || owner_c == DBG) begin
        streak_nxt = '0;
      end else if (owner_c == CPU && streak != STREAK_MAX) begin
        streak_nxt = streak + STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else begin
      streak <= streak_nxt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter (CPU priority, debug port) with a zero-fill sequencer.
// Optional per-port grant counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned CPU_BURST = DEF_CPU_BURST,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_write_select,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_read_select,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       cpu_gnt_cnt,
  output logic [15:0]       dbg_gnt_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e              state;
  state_e              state_nxt;
  logic [ADDR_W-1:0]   clr_addr;
  logic [ADDR_W-1:0]   clr_addr_nxt;
  logic                clr_done_nxt;
  logic                hold;
  owner_e              owner;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   dbg_rdata_q;

  // Grants are suppressed while sweeping and while reset is asserted
  assign hold = reset | (state == CLEAR);

  dmem_rr_pick #(
    .CPU_BURST (CPU_BURST)
  ) u_pick (
    .clock   (clock),
    .reset   (reset),
    .hold    (hold),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .owner_c (owner)
  );

  assign cpu_gnt  = (owner == CPU);
  assign dbg_gnt  = (owner == DBG);
  assign clr_busy = (state == CLEAR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clr_addr <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      clr_done <= clr_done_nxt;
    end
  end

  // Zero-fill sequencer: one location per cycle, done pulse after the last write
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    clr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      CLEAR: begin
        clr_addr_nxt = clr_addr + ADDR_W'(1);
        if (clr_addr == LAST_ADDR) begin
          state_nxt    = IDLE;
          clr_addr_nxt = '0;
          clr_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port mux; the sweep overrides the write side
  always_comb begin
    mem_we           = 1'b0;
    mem_write_select = '0;
    mem_wdata        = '0;
    mem_read_select  = '0;
    case (owner)
      CPU: begin
        mem_we           = cpu_we;
        mem_write_select = cpu_addr;
        mem_wdata        = cpu_wdata;
        mem_read_select  = cpu_addr;
      end
      DBG: begin
        mem_we           = dbg_we;
        mem_write_select = dbg_addr;
        mem_wdata        = dbg_wdata;
        mem_read_select  = dbg_addr;
      end
      default: ;
    endcase
    if (state == CLEAR) begin
      mem_we           = 1'b1;
      mem_write_select = clr_addr;
      mem_wdata        = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_rvalid  <= 1'b0;
      dbg_rvalid  <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
    end
  end

  // Memory output is already registered; present it directly in the rvalid cycle, then hold
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_gnt_cnt <= '0;
      dbg_gnt_cnt <= '0;
    end else if (clr_start) begin
      cpu_gnt_cnt <= '0;
      dbg_gnt_cnt <= '0;
    end else begin
      if (cpu_gnt && cpu_gnt_cnt != 16'hFFFF) cpu_gnt_cnt <= cpu_gnt_cnt + 16'd1;
      if (dbg_gnt && dbg_gnt_cnt != 16'hFFFF) dbg_gnt_cnt <= dbg_gnt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural memory/arbitration model.
module tb_dmem_arbiter;

  localparam int unsigned BURST = 4;
  localparam int unsigned DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic       clr_start, clr_busy, clr_done;
  logic       mem_we;
  logic [3:0] mem_write_select, mem_read_select;
  logic [7:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cpu_gnt_cnt, dbg_gnt_cnt;
`endif

  dmem_arbiter #(.CPU_BURST(BURST), .ADDR_W(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_we(mem_we), .mem_write_select(mem_write_select), .mem_wdata(mem_wdata),
    .mem_read_select(mem_read_select),
`ifdef DMEM_ARB_STATS_EN
    .cpu_gnt_cnt(cpu_gnt_cnt), .dbg_gnt_cnt(dbg_gnt_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Single-port 16x8 memory with registered read data
  logic [7:0] mem [DEPTH];
  always @(posedge clock) begin
    if (mem_we) mem[mem_write_select] <= mem_wdata;
    mem_rdata <= mem[mem_read_select];
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] ref_mem [DEPTH];
  bit         m_clearing, m_done, m_crv, m_drv;
  int         m_idx, m_streak;
  logic [7:0] m_crd, m_drd;
  bit         last_cg, last_dg, last_busy, last_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clearing = 1'b0; m_done = 1'b0; m_crv = 1'b0; m_drv = 1'b0;
    m_idx = 0; m_streak = 0; m_crd = 8'h00; m_drd = 8'h00;
  endtask

  task automatic step(input bit cr, input bit cw, input logic [3:0] ca, input logic [7:0] cd,
                      input bit dr, input bit dw, input logic [3:0] da, input logic [7:0] dd,
                      input bit cs);
    bit eg_c, eg_d, ewe;
    @(negedge clock);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    clr_start = cs;
    #1;
    eg_c = 1'b0; eg_d = 1'b0;
    if (!m_clearing) begin
      if (cr && dr) begin
        if (m_streak >= int'(BURST)) eg_d = 1'b1; else eg_c = 1'b1;
      end else if (cr) eg_c = 1'b1;
      else if (dr) eg_d = 1'b1;
    end
    ewe = m_clearing || (eg_c && cw) || (eg_d && dw);
    chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(eg_d));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_crd));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_drv));
    chk("dbg_rdata", 32'(dbg_rdata), 32'(m_drd));
    chk("clr_busy", 32'(clr_busy), 32'(m_clearing));
    chk("clr_done", 32'(clr_done), 32'(m_done));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    if (m_clearing) begin
      chk("clr_waddr", 32'(mem_write_select), 32'(m_idx));
      chk("clr_wdata", 32'(mem_wdata), 32'h0);
    end
    last_cg = cpu_gnt; last_dg = dbg_gnt; last_busy = clr_busy; last_done = clr_done;

    // Advance the model across the coming rising edge
    m_crv = eg_c && !cw;
    if (m_crv) m_crd = ref_mem[ca];
    m_drv = eg_d && !dw;
    if (m_drv) m_drd = ref_mem[da];
    if (eg_c && cw) ref_mem[ca] = cd;
    if (eg_d && dw) ref_mem[da] = dd;
    if (!m_clearing) begin
      if (!dr || eg_d) m_streak = 0;
      else if (eg_c && m_streak < int'(BURST)) m_streak++;
    end
    if (m_clearing) begin
      ref_mem[m_idx] = 8'h00;
      m_idx++;
      m_done = 1'b0;
      if (m_idx == int'(DEPTH)) begin
        m_clearing = 1'b0; m_idx = 0; m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (cs) begin m_clearing = 1'b1; m_idx = 0; end
    end
  endtask

  task automatic idle();
    step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0);
  endtask

  task automatic preload_ff();
    for (int a = 0; a < int'(DEPTH); a++) step(1, 1, 4'(a), 8'hFF, 0, 0, 4'h0, 8'h00, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq;
    int busy_n, gnt_n, done_n;

    for (int a = 0; a < int'(DEPTH); a++) begin mem[a] = 8'h00; ref_mem[a] = 8'h00; end
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 8'h00;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'h0; dbg_wdata = 8'h00;
    clr_start = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 32'h0);
    chk("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'h0);
    chk("rst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'h0);
    chk("rst_clr", 32'({clr_busy, clr_done}), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // CPU write then read back
    step(1, 1, 4'd3, 8'hA5, 0, 0, 4'h0, 8'h00, 0);
    step(1, 0, 4'd3, 8'h00, 0, 0, 4'h0, 8'h00, 0);
    idle();
    chk("t1_cpu_rdata", 32'(cpu_rdata), 32'hA5);

    // Both requesting: CPU wins four times, then debug
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 4'(i), 8'h00, 1, 0, 4'(15 - i), 8'h00, 0);
      seq[i] = last_dg;
    end
    chk("burst_seq", 32'(seq), 32'h210);
    idle();

    // Debug write then read back
    step(0, 0, 4'h0, 8'h00, 1, 1, 4'd7, 8'h3C, 0);
    step(0, 0, 4'h0, 8'h00, 1, 0, 4'd7, 8'h00, 0);
    idle();
    chk("t3_dbg_rdata", 32'(dbg_rdata), 32'h3C);

    // Full zero-fill with both ports hammering
    preload_ff();
    step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1);
    busy_n = 0; gnt_n = 0; done_n = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) step(1, 0, 4'($urandom_range(0, 15)), 8'h00, 1, 1, 4'($urandom_range(0, 15)), 8'h55, 1);
      else idle();
      busy_n += int'(last_busy);
      gnt_n  += int'(last_cg) + int'(last_dg);
      done_n += int'(last_done);
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd16);
    chk("clr_gnt_count", 32'(gnt_n), 32'd0);
    chk("clr_done_pulses", 32'(done_n), 32'd1);
    for (int a = 0; a < int'(DEPTH); a++) step(1, 0, 4'(a), 8'h00, 0, 0, 4'h0, 8'h00, 0);
    idle();

    // Reset in the sixth sweep cycle
    preload_ff();
    step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1);
    for (int i = 0; i < 5; i++) idle();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(clr_busy), 32'h0);
    chk("abort_mem_we", 32'(mem_we), 32'h0);
    chk("abort_done", 32'(clr_done), 32'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    done_n = 0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      step(0, 0, 4'h0, 8'h00, 1, 0, 4'(a), 8'h00, 0);
      done_n += int'(last_done);
    end
    idle();
    chk("abort_done_pulses", 32'(done_n), 32'd0);
    chk("abort_addr15", 32'(dbg_rdata), 32'hFF);

    // Randomized traffic with occasional sweeps
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
           $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 18; i++) idle();

`ifdef DMEM_ARB_STATS_EN
    step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1);
    for (int i = 0; i < 17; i++) idle();
    for (int i = 0; i < 5; i++) step(1, 0, 4'(i), 8'h00, 0, 0, 4'h0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 8'h00, 1, 0, 4'(i), 8'h00, 0);
    idle();
    chk("cpu_gnt_cnt", 32'(cpu_gnt_cnt), 32'd5);
    chk("dbg_gnt_cnt", 32'(dbg_gnt_cnt), 32'd3);
    step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1);
    idle();
    chk("cpu_gnt_cnt_clr", 32'(cpu_gnt_cnt), 32'd0);
    chk("dbg_gnt_cnt_clr", 32'(dbg_gnt_cnt), 32'd0);
    for (int i = 0; i < 17; i++) idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
